operand_fetch: RTL and testbench

Sequencer that sits directly upstream of the single-port 32x32 register file and owns its only port. It serialises source-operand reads for decoded instructions and destination writebacks from the execute/writeback stage onto that one port. Captured rs1/rs2 values are presented to execute through a valid/ready handshake. It enforces x0 semantics: reads return 0 and writes are discarded.

---
 rtl/operand_fetch.sv | 162 ++++++++++++++++
 tb/tb_operand_fetch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// ----------------------------------------------------------------------------
// operand_fetch
// Owns the single port of a 32x32 register file. Writebacks and source-operand
// reads share the port: writebacks are taken only in IDLE and win over a new
// decoded instruction offered in the same cycle. An accepted instruction reads
// rs1 (RD1), then rs2 (RD2) if needed, and presents both operands to execute
// (OUT) until op_ready_i. Register x0 always reads 0 and writes to it are dropped.
//
// Optional build macro: OPERAND_FETCH_X0_SKIP_EN
//   defined   - read states whose index is 0 are skipped (operand loaded with 0)
//   undefined - every read state is visited, x0 reads are forced to 0
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   dec_valid_i / dec_ready_o  decoded instruction handshake
//   rs1_i, rs2_i, use_rs2_i    source indices, rs2 needed flag
//   wb_valid_i / wb_ready_o    writeback handshake
//   wb_rd_i, wb_data_i         writeback destination and data
//   rf_regno_o, rf_write_o     register file index / write enable
//   rf_wdata_o, rf_rdata_i     register file write / read data
//   op_valid_o / op_ready_i    operand handshake to execute
//   op_a_o, op_b_o             rs1 / rs2 values
// ----------------------------------------------------------------------------
module operand_fetch #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REGNO_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec_valid_i,
    output logic               dec_ready_o,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic               use_rs2_i,
    input  logic               wb_valid_i,
    output logic               wb_ready_o,
    input  logic [4:0]         wb_rd_i,
    input  logic [XLEN-1:0]    wb_data_i,
    output logic [REGNO_W-1:0] rf_regno_o,
    output logic               rf_write_o,
    output logic [XLEN-1:0]    rf_wdata_o,
    input  logic [XLEN-1:0]    rf_rdata_i,
    output logic               op_valid_o,
    input  logic               op_ready_i,
    output logic [XLEN-1:0]    op_a_o,
    output logic [XLEN-1:0]    op_b_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD1  = 2'd1;
    localparam logic [1:0] RD2  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic            use_rs2_q, use_rs2_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;

    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_rs2_d   = use_rs2_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        dec_ready_o = 1'b0;
        wb_ready_o  = 1'b0;
        rf_write_o  = 1'b0;
        rf_regno_o  = '0;
        rf_wdata_o  = wb_data_i;

        case (state_q)
            IDLE: begin
                wb_ready_o  = 1'b1;
                dec_ready_o = !wb_valid_i;
                if (wb_valid_i) begin
                    rf_regno_o = REGNO_W'(wb_rd_i);
                    rf_write_o = (wb_rd_i != 5'd0);
                end
                if (dec_valid_i && !wb_valid_i) begin
                    rs1_d     = rs1_i;
                    rs2_d     = rs2_i;
                    use_rs2_d = use_rs2_i;
`ifdef OPERAND_FETCH_X0_SKIP_EN
                    if (rs1_i != 5'd0) begin
                        state_d = RD1;
                    end else begin
                        op_a_d = '0;
                        if (use_rs2_i && (rs2_i != 5'd0)) begin
                            state_d = RD2;
                        end else begin
                            op_b_d  = '0;
                            state_d = OUT;
                        end
                    end
`else
                    state_d = RD1;
`endif
                end
            end
            RD1: begin
                rf_regno_o = REGNO_W'(rs1_q);
                // The file itself may hold anything at index 0
                op_a_d     = (rs1_q == 5'd0) ? '0 : rf_rdata_i;
`ifdef OPERAND_FETCH_X0_SKIP_EN
                if (use_rs2_q && (rs2_q != 5'd0)) begin
`else
                if (use_rs2_q) begin
`endif
                    state_d = RD2;
                end else begin
                    op_b_d  = '0;
                    state_d = OUT;
                end
            end
            RD2: begin
                rf_regno_o = REGNO_W'(rs2_q);
                op_b_d     = (rs2_q == 5'd0) ? '0 : rf_rdata_i;
                state_d    = OUT;
            end
            OUT: begin
                if (op_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // No port activity or handshakes while reset is asserted
        if (!rst_n) begin
            dec_ready_o = 1'b0;
            wb_ready_o  = 1'b0;
            rf_write_o  = 1'b0;
            rf_regno_o  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_rs2_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_rs2_q <= use_rs2_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
        end
    end

    assign op_valid_o = (state_q == OUT);
    assign op_a_o     = op_a_q;
    assign op_b_o     = op_b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// ----------------------------------------------------------------------------
// tb_operand_fetch
// Bench for operand_fetch. Models the register file (falling-edge write,
// combinational read, garbage stored at index 0) and keeps an architectural
// view of register contents updated on accepted writebacks. Directed table
// vectors, hand-written reset/priority sequences and random traffic.
// ----------------------------------------------------------------------------
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_ready;
    logic [4:0]  rs1, rs2;
    logic        use_rs2;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  rf_regno;
    logic        rf_write;
    logic [31:0] rf_wdata, rf_rdata;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(32), .REGNO_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_valid_i(dec_valid),
        .dec_ready_o(dec_ready),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .use_rs2_i  (use_rs2),
        .wb_valid_i (wb_valid),
        .wb_ready_o (wb_ready),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .rf_regno_o (rf_regno),
        .rf_write_o (rf_write),
        .rf_wdata_o (rf_wdata),
        .rf_rdata_i (rf_rdata),
        .op_valid_o (op_valid),
        .op_ready_i (op_ready),
        .op_a_o     (op_a),
        .op_b_o     (op_b)
    );

    // Register file environment
    logic [31:0] rf_mem [32];
    logic [31:0] gold   [32];
    logic        preload;

    assign rf_rdata = rf_mem[rf_regno[4:0]];

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'hBAD0BAD0 : gold[i];
        end else if (rf_write) begin
            rf_mem[rf_regno[4:0]] <= rf_wdata;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from acceptance edge to first op_valid cycle
    function automatic int exp_lat(input logic [4:0] r1, input logic [4:0] r2, input logic u);
`ifdef OPERAND_FETCH_X0_SKIP_EN
        return 1 + ((r1 != 5'd0) ? 1 : 0) + ((u && (r2 != 5'd0)) ? 1 : 0);
`else
        return 2 + (u ? 1 : 0);
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
        wb_valid  = 1'b0;
        dec_valid = 1'b0;
        op_ready  = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] rd, input logic [31:0] data);
        dec_valid = 1'b0;
        op_ready  = 1'b0;
        wb_valid  = 1'b1;
        wb_rd     = rd;
        wb_data   = data;
        #1;
        chk1("wb_ready", wb_ready, 1'b1);
        chk1("wb_rf_write", rf_write, rd != 5'd0);
        chk1("regno_msb", rf_regno[5], 1'b0);
        tick();
        wb_valid = 1'b0;
        if (rd != 5'd0) gold[rd] = data;
    endtask

    task automatic do_instr(input logic [4:0] r1, input logic [4:0] r2, input logic u,
                            input int hold, input logic [31:0] ea, input logic [31:0] eb);
        int lat;
        bit seen;
        wb_valid  = 1'b0;
        op_ready  = 1'b0;
        dec_valid = 1'b1;
        rs1       = r1;
        rs2       = r2;
        use_rs2   = u;
        #1;
        chk1("dec_ready_idle", dec_ready, 1'b1);
        tick();
        // Scramble inputs to prove the indices were latched; offer junk writeback
        dec_valid = 1'b0;
        rs1       = 5'($urandom);
        rs2       = 5'($urandom);
        use_rs2   = 1'($urandom);
        wb_valid  = 1'b1;
        wb_rd     = 5'($urandom_range(1, 31));
        wb_data   = $urandom;
        lat  = 1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (op_valid) begin
                seen = 1;
                break;
            end
            chk1("busy_wb_ready", wb_ready, 1'b0);
            chk1("busy_rf_write", rf_write, 1'b0);
            tick();
            lat++;
        end
        if (!seen) begin
            chk1("op_valid_timeout", op_valid, 1'b1);
            do_reset();
            return;
        end
        chk("latency", 32'(lat), 32'(exp_lat(r1, r2, u)));
        wb_valid  = 1'b0;
        dec_valid = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            chk1("out_valid", op_valid, 1'b1);
            chk("op_a", op_a, ea);
            chk("op_b", op_b, eb);
            chk1("out_dec_ready", dec_ready, 1'b0);
            chk1("out_wb_ready", wb_ready, 1'b0);
            if (h < hold) begin
                tick();
                #1;
            end
        end
        op_ready  = 1'b1;
        dec_valid = 1'b0;
        tick();
        op_ready = 1'b0;
        #1;
        chk1("valid_drop", op_valid, 1'b0);
        chk1("back_idle", dec_ready, 1'b1);
    endtask

    typedef struct {
        bit          is_wb;
        logic [4:0]  a;      // wb rd or rs1
        logic [4:0]  b;      // rs2
        logic        u;
        int          hold;
        logic [31:0] data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [10];

    initial begin
        rst_n     = 1'b0;
        dec_valid = 1'b1;
        rs1       = 5'd1;
        rs2       = 5'd2;
        use_rs2   = 1'b1;
        wb_valid  = 1'b1;
        wb_rd     = 5'd4;
        wb_data   = 32'h11111111;
        op_ready  = 1'b0;
        gold[0]   = 32'h0;
        for (int i = 1; i < 32; i++) gold[i] = $urandom;
        preload = 1'b1;
        tick();
        tick();
        preload = 1'b0;
        // Reset state
        chk1("rst_op_valid", op_valid, 1'b0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_op_b", op_b, 32'h0);
        chk1("rst_dec_ready", dec_ready, 1'b0);
        chk1("rst_wb_ready", wb_ready, 1'b0);
        chk1("rst_rf_write", rf_write, 1'b0);
        rst_n     = 1'b1;
        wb_valid  = 1'b0;
        dec_valid = 1'b0;
        #1;
        chk1("idle_dec_ready", dec_ready, 1'b1);
        chk1("idle_wb_ready", wb_ready, 1'b1);
        chk("idle_regno", 32'(rf_regno), 32'h0);

        // Directed vectors
        vecs[0] = '{1'b1, 5'd5,  5'd0,  1'b0, 0, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd5,  5'd0,  1'b1, 0, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  5'd0,  1'b0, 0, 32'hFFFFFFFF, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd0,  5'd0,  1'b1, 0, 32'h0,        32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd3,  5'd0,  1'b0, 0, 32'h00000042, 32'h0,        32'h0};
        vecs[5] = '{1'b0, 5'd3,  5'd9,  1'b0, 0, 32'h0,        32'h00000042, 32'h0};
        vecs[6] = '{1'b1, 5'd12, 5'd0,  1'b0, 0, 32'hA5A50001, 32'h0,        32'h0};
        vecs[7] = '{1'b0, 5'd12, 5'd5,  1'b1, 5, 32'h0,        32'hA5A50001, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd0,  5'd12, 1'b1, 1, 32'h0,        32'h0,        32'hA5A50001};
        vecs[9] = '{1'b0, 5'd5,  5'd5,  1'b0, 2, 32'h0,        32'hDEADBEEF, 32'h0};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wb) do_wb(vecs[i].a, vecs[i].data);
            else do_instr(vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].hold,
                          vecs[i].exp_a, vecs[i].exp_b);
        end

        // Simultaneous writeback and decode: writeback first
        wb_valid  = 1'b1;
        wb_rd     = 5'd7;
        wb_data   = 32'h12345678;
        dec_valid = 1'b1;
        rs1       = 5'd7;
        rs2       = 5'd0;
        use_rs2   = 1'b0;
        #1;
        chk1("sim_dec_ready", dec_ready, 1'b0);
        chk1("sim_wb_ready", wb_ready, 1'b1);
        chk1("sim_rf_write", rf_write, 1'b1);
        tick();
        wb_valid = 1'b0;
        gold[7]  = 32'h12345678;
        do_instr(5'd7, 5'd0, 1'b0, 0, 32'h12345678, 32'h0);

        // Reset in the middle of RD2
        do_wb(5'd9, 32'hCAFEF00D);
        dec_valid = 1'b1;
        rs1       = 5'd9;
        rs2       = 5'd9;
        use_rs2   = 1'b1;
        #1;
        tick();
        dec_valid = 1'b0;
        tick();
        rst_n     = 1'b0;
        wb_valid  = 1'b1;
        wb_rd     = 5'd4;
        wb_data   = ~gold[4];
        dec_valid = 1'b1;
        #1;
        chk1("mid_rst_wb_ready", wb_ready, 1'b0);
        chk1("mid_rst_dec_ready", dec_ready, 1'b0);
        chk1("mid_rst_rf_write", rf_write, 1'b0);
        tick();
        chk1("mid_rst_valid1", op_valid, 1'b0);
        chk1("mid_rst_rf_write1", rf_write, 1'b0);
        tick();
        chk1("mid_rst_valid2", op_valid, 1'b0);
        chk("mid_rst_op_a", op_a, 32'h0);
        chk("mid_rst_op_b", op_b, 32'h0);
        rst_n     = 1'b1;
        wb_valid  = 1'b0;
        dec_valid = 1'b0;
        #1;
        chk1("post_rst_idle", dec_ready, 1'b1);
        chk("post_rst_no_write", rf_mem[4], gold[4]);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("post_rst_no_valid", op_valid, 1'b0);
        end

        // Random traffic against the architectural model
        for (int i = 0; i < 60; i++) begin
            logic [4:0] r1, r2;
            logic       u;
            if ($urandom_range(0, 2) == 0) begin
                r1 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
                do_wb(r1, $urandom);
            end else begin
                r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                u  = 1'($urandom);
                do_instr(r1, r2, u, int'($urandom_range(0, 3)), gold[r1],
                         u ? gold[r2] : 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
